// File: rtl/id_issue_stage_pkg.sv
// Shared decode constants and ALU op encodings for the issue stage and execution unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_issue_stage_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  // ALU operation encoding, shared with the execution unit
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Upper six bits of a shift-immediate (bit 25 belongs to the 6-bit shamt)
  localparam logic [5:0] SHIFT_HI_BASE = 6'b000000;
  localparam logic [5:0] SHIFT_HI_SRA  = 6'b010000;

  // One-hot register mask; x0 maps to an empty mask so it can never be marked busy
  function automatic logic [NREG-1:0] reg_onehot(input logic [4:0] r);
    logic [NREG-1:0] m;
    m = '0;
    if (r != 5'd0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/id_issue_stage_regfile.sv
// 32x64 integer register file: two combinational read ports, one write port, x0 hardwired to 0.
// Latency: reads are combinational; a same-cycle writeback is forwarded to the readers.
// Backpressure: none, every write is accepted (writes are dropped while rst is high).
module regfile_32x64
  import id_issue_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NREG];

  // Write port: reset clears every entry, x0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Read ports with write-through bypass so a same-cycle writeback is visible
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != 5'd0) rs1_data = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    if (rs2 != 5'd0) rs2_data = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
  end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes RV64 integer ALU ops, reads operands, blocks on scoreboard hazards.
// Latency: one cycle from accept to a registered bundle on ex_valid.
// Backpressure: in_ready drops on a hazard or while a bundle waits on ex_ready; the bundle holds stable.
module id_issue_stage
  import id_issue_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      op,
  output logic            alusrc,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rs1_data, rs2_data;

  alu_op_e         dec_op;
  logic            dec_legal;
  logic            dec_itype;
  logic [XLEN-1:0] dec_imm;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] clr_mask, set_mask;
  logic            is_rtype, hazard, accept;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign funct7  = instr[31:25];

  regfile_32x64 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1_idx),
    .rs2      (rs2_idx),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  // Decode opcode/funct fields into an ALU op, legality and the immediate
  always_comb begin
    dec_op    = ALU_ADD;
    dec_legal = 1'b0;
    dec_itype = 1'b0;
    dec_imm   = '0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          case (funct3)
            F3_ADD_SUB: dec_op = ALU_ADD;
            F3_SLL:     dec_op = ALU_SLL;
            F3_SLT:     dec_op = ALU_SLT;
            F3_SLTU:    dec_op = ALU_SLTU;
            F3_XOR:     dec_op = ALU_XOR;
            F3_SRL_SRA: dec_op = ALU_SRL;
            F3_OR:      dec_op = ALU_OR;
            default:    dec_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        dec_itype = 1'b1;
        dec_imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (funct3)
          F3_ADD_SUB: begin dec_legal = 1'b1; dec_op = ALU_ADD;  end
          F3_SLT:     begin dec_legal = 1'b1; dec_op = ALU_SLT;  end
          F3_SLTU:    begin dec_legal = 1'b1; dec_op = ALU_SLTU; end
          F3_XOR:     begin dec_legal = 1'b1; dec_op = ALU_XOR;  end
          F3_OR:      begin dec_legal = 1'b1; dec_op = ALU_OR;   end
          F3_AND:     begin dec_legal = 1'b1; dec_op = ALU_AND;  end
          F3_SLL: begin
            dec_imm   = {{(XLEN-6){1'b0}}, instr[25:20]};
            dec_legal = (instr[31:26] == SHIFT_HI_BASE);
            dec_op    = dec_legal ? ALU_SLL : ALU_ADD;
          end
          default: begin
            dec_imm = {{(XLEN-6){1'b0}}, instr[25:20]};
            if (instr[31:26] == SHIFT_HI_BASE) begin
              dec_legal = 1'b1;
              dec_op    = ALU_SRL;
            end else if (instr[31:26] == SHIFT_HI_SRA) begin
              dec_legal = 1'b1;
              dec_op    = ALU_SRA;
            end
          end
        endcase
      end
      default: ;
    endcase
  end

  // Hazard check: a busy bit being retired this cycle no longer blocks issue
  always_comb begin
    clr_mask = wb_en ? reg_onehot(wb_rd) : '0;
    busy_eff = busy & ~clr_mask;
    is_rtype = (opcode == OPC_OP);
    hazard   = busy_eff[rs1_idx] | (is_rtype & busy_eff[rs2_idx]) | busy_eff[rd_idx];
    in_ready = !hazard && (!ex_valid || ex_ready);
    accept   = in_valid && in_ready;
    set_mask = (accept && dec_legal) ? reg_onehot(rd_idx) : '0;
  end

  // Scoreboard: set applied after clear so an accept to the retiring rd keeps it busy
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end

  // Issue bundle register; illegal instructions issue as a harmless ADD with no writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      op        <= 4'd0;
      alusrc    <= 1'b0;
      rd        <= 5'd0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      ex_valid  <= 1'b1;
      a         <= rs1_data;
      b         <= (dec_legal && !dec_itype) ? rs2_data : '0;
      imm       <= (dec_legal && dec_itype) ? dec_imm : '0;
      op        <= dec_op;
      alusrc    <= dec_legal && dec_itype;
      rd        <= rd_idx;
      reg_write <= dec_legal;
      illegal   <= !dec_legal;
    end else if (ex_ready) begin
      ex_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed cycle table, then randomized traffic against a reference model.
// Latency: inputs driven 1ns after the rising edge, outputs compared on the falling edge.
// Backpressure: ex_ready is scripted in the table and randomized afterwards.
module tb_id_issue_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_en, ex_valid, ex_ready;
  logic [31:0] instr;
  logic [4:0]  wb_rd, rd;
  logic [63:0] wb_data, a, b, imm;
  logic [3:0]  op;
  logic        alusrc, reg_write, illegal;

  always #5 clk = ~clk;

  id_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .a(a), .b(b), .imm(imm), .op(op), .alusrc(alusrc), .rd(rd),
    .reg_write(reg_write), .illegal(illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [203:0] bundle_act;
  assign bundle_act = {a, b, imm, op, alusrc, rd, reg_write, illegal};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [203:0] bnd(input logic [63:0] ea, input logic [63:0] eb, input logic [63:0] ei,
                                       input logic [3:0] eo, input logic es, input logic [4:0] er,
                                       input logic ew, input logic el);
    return {ea, eb, ei, eo, es, er, ew, el};
  endfunction

  typedef struct {
    logic         r, iv;
    logic [31:0]  ins;
    logic         we;
    logic [4:0]   wrd;
    logic [63:0]  wd;
    logic         er;
    logic         e_ir, e_ev, chk;
    logic [203:0] e_bnd;
  } vec_t;

  function automatic vec_t v(input logic r, input logic iv, input logic [31:0] ins, input logic we,
                             input logic [4:0] wrd, input logic [63:0] wd, input logic er,
                             input logic e_ir, input logic e_ev, input logic chk, input logic [203:0] eb);
    vec_t t;
    t.r = r; t.iv = iv; t.ins = ins; t.we = we; t.wrd = wrd; t.wd = wd; t.er = er;
    t.e_ir = e_ir; t.e_ev = e_ev; t.chk = chk; t.e_bnd = eb;
    return t;
  endfunction

  // ---------------- reference model ----------------
  localparam logic [3:0] R_OPS [8] = '{4'd0, 4'd6, 4'd8, 4'd9, 4'd4, 4'd5, 4'd3, 4'd2};

  logic [63:0]  m_reg [32];
  bit           m_busy [32];
  logic [203:0] m_bnd;
  bit           m_ev;

  task automatic ref_decode(input logic [31:0] ins, output bit legal, output bit itype,
                            output logic [3:0] mop, output logic [63:0] mimm);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] hi6;
    f3 = ins[14:12]; f7 = ins[31:25]; hi6 = ins[31:26];
    legal = 0; itype = 0; mop = 4'd0; mimm = 64'd0;
    if (ins[6:0] == 7'h33) begin
      if (f7 == 7'h00) begin legal = 1; mop = R_OPS[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1; mop = 4'd1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1; mop = 4'd7; end
    end else if (ins[6:0] == 7'h13) begin
      itype = 1;
      if (f3 == 3'd1) begin
        legal = (hi6 == 6'd0); mop = 4'd6; mimm = {58'd0, ins[25:20]};
      end else if (f3 == 3'd5) begin
        legal = (hi6 == 6'd0) || (hi6 == 6'd16); mop = (hi6 == 6'd16) ? 4'd7 : 4'd5;
        mimm = {58'd0, ins[25:20]};
      end else begin
        legal = 1; mop = R_OPS[f3]; mimm = {{52{ins[31]}}, ins[31:20]};
      end
    end
    if (!legal) mop = 4'd0;
  endtask

  function automatic bit busy_now(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic logic [63:0] read_now(input logic [4:0] r);
    if (r == 5'd0) return 64'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_reg[r];
  endfunction

  // ---------------- directed table ----------------
  localparam int NV = 19;
  vec_t tbl [NV];

  localparam logic [31:0] ADDI1   = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] ADD2    = 32'h00108133;  // add  x2,x1,x1
  localparam logic [31:0] SRAI3   = 32'h43F15193;  // srai x3,x2,63
  localparam logic [31:0] SLLIBAD = 32'h04001293;  // slli x5,x0 with instr[31:26]=000001
  localparam logic [31:0] ADDI6   = 32'h00300313;  // addi x6,x0,3
  localparam logic [31:0] ADD7    = 32'h000003B3;  // add  x7,x0,x0
  localparam logic [31:0] ADDI0   = 32'h00100013;  // addi x0,x0,1
  localparam logic [31:0] ADD0    = 32'h00000033;  // add  x0,x0,x0
  localparam logic [31:0] ADDI4   = 32'h00700213;  // addi x4,x0,7
  localparam logic [31:0] ADD5    = 32'h001202B3;  // add  x5,x4,x1
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [203:0] b_addi1, b_add2, b_srai, b_ill, b_addi6, b_add7, b_addi0, b_add0, b_addi4, b_add5;
    bit           legal, itype, haz, e_ir, acc;
    logic [3:0]   mop;
    logic [63:0]  mimm;
    logic [4:0]   r1, r2, rdn;
    logic [6:0]   f7;
    logic [2:0]   f3;
    logic [5:0]   hi6;
    logic [4:0]   busy_list [$];

    b_addi1 = bnd(64'd0, 64'd0, 64'd5, 4'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    b_add2  = bnd(64'd5, 64'd5, 64'd0, 4'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    b_srai  = bnd(64'h123, 64'd0, 64'd63, 4'd7, 1'b1, 5'd3, 1'b1, 1'b0);
    b_ill   = bnd(64'd0, 64'd0, 64'd0, 4'd0, 1'b0, 5'd5, 1'b0, 1'b1);
    b_addi6 = bnd(64'd0, 64'd0, 64'd3, 4'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    b_add7  = bnd(64'd0, 64'd0, 64'd0, 4'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    b_addi0 = bnd(64'd0, 64'd0, 64'd1, 4'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    b_add0  = bnd(64'd0, 64'd0, 64'd0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    b_addi4 = bnd(64'd0, 64'd0, 64'd7, 4'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    b_add5  = bnd(64'd0, 64'd0, 64'd0, 4'd0, 1'b0, 5'd5, 1'b1, 1'b0);

    //              r  iv ins      we wrd    wd       er  ir ev chk bundle
    tbl[0]  = v(0, 0, 32'd0,   0, 5'd0, 64'd0,   1,  1, 0, 1, 204'd0);   // reset state
    tbl[1]  = v(0, 1, ADDI1,   0, 5'd0, 64'd0,   1,  1, 0, 0, 204'd0);
    tbl[2]  = v(0, 1, ADD2,    0, 5'd0, 64'd0,   1,  0, 1, 1, b_addi1);  // RAW on x1
    tbl[3]  = v(0, 1, ADD2,    1, 5'd1, 64'd5,   1,  1, 0, 0, 204'd0);   // wb clears x1, bypass
    tbl[4]  = v(0, 1, SRAI3,   0, 5'd0, 64'd0,   1,  0, 1, 1, b_add2);   // RAW on x2
    tbl[5]  = v(0, 1, SRAI3,   1, 5'd2, 64'h123, 1,  1, 0, 0, 204'd0);
    tbl[6]  = v(0, 1, SLLIBAD, 0, 5'd0, 64'd0,   1,  1, 1, 1, b_srai);
    tbl[7]  = v(0, 0, 32'd0,   1, 5'd3, 64'd9,   0,  0, 1, 1, b_ill);    // back-pressure 1
    tbl[8]  = v(0, 1, ADDI6,   0, 5'd0, 64'd0,   0,  0, 1, 1, b_ill);    // back-pressure 2
    tbl[9]  = v(0, 1, ADDI6,   0, 5'd0, 64'd0,   0,  0, 1, 1, b_ill);    // back-pressure 3
    tbl[10] = v(0, 1, ADDI6,   0, 5'd0, 64'd0,   1,  1, 1, 1, b_ill);    // release
    tbl[11] = v(0, 0, 32'd0,   1, 5'd0, ONES,    1,  1, 1, 1, b_addi6);  // write to x0
    tbl[12] = v(0, 1, ADD7,    1, 5'd0, ONES,    1,  1, 0, 0, 204'd0);   // x0 bypass attempt
    tbl[13] = v(0, 1, ADDI0,   0, 5'd0, 64'd0,   1,  1, 1, 1, b_add7);
    tbl[14] = v(0, 1, ADD0,    0, 5'd0, 64'd0,   1,  1, 1, 1, b_addi0);  // x0 never busy
    tbl[15] = v(0, 1, ADDI4,   0, 5'd0, 64'd0,   1,  1, 1, 1, b_add0);
    tbl[16] = v(1, 0, 32'd0,   1, 5'd1, 64'hDEAD, 0, 0, 1, 1, b_addi4);  // reset mid-flight
    tbl[17] = v(0, 1, ADD5,    0, 5'd0, 64'd0,   1,  1, 0, 1, 204'd0);   // x4 not busy, bundle cleared
    tbl[18] = v(0, 0, 32'd0,   0, 5'd0, 64'd0,   1,  1, 1, 1, b_add5);   // regs read 0 after reset

    rst = 1; in_valid = 0; instr = 0; wb_en = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].r; in_valid = tbl[i].iv; instr = tbl[i].ins; wb_en = tbl[i].we;
      wb_rd = tbl[i].wrd; wb_data = tbl[i].wd; ex_ready = tbl[i].er;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), {255'd0, in_ready}, {255'd0, tbl[i].e_ir});
      check($sformatf("vec%0d_ex_valid", i), {255'd0, ex_valid}, {255'd0, tbl[i].e_ev});
      if (tbl[i].chk) check($sformatf("vec%0d_bundle", i), {52'd0, bundle_act}, {52'd0, tbl[i].e_bnd});
      @(posedge clk);
      #1;
    end

    // ---------------- randomized phase ----------------
    rst = 1; in_valid = 0; instr = 0; wb_en = 0; ex_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 32; i++) begin m_reg[i] = 64'd0; m_busy[i] = 0; end
    m_ev = 0; m_bnd = '0;

    for (int c = 0; c < 3000; c++) begin
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); rdn = 5'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 4)) 0: f7 = 7'h20; 1: f7 = 7'h01; default: f7 = 7'h00; endcase
          instr = {f7, r2, r1, f3, rdn, 7'h33};
        end
        1: instr = {12'($urandom), r1, f3, rdn, 7'h13};
        2: begin
          case ($urandom_range(0, 2)) 0: hi6 = 6'd0; 1: hi6 = 6'd16; default: hi6 = 6'd1; endcase
          instr = {hi6, 6'($urandom), r1, ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd1, rdn, 7'h13};
        end
        default: instr = $urandom;
      endcase
      in_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      busy_list.delete();
      for (int k = 1; k < 32; k++) if (m_busy[k]) busy_list.push_back(5'(k));
      wb_en = ($urandom_range(0, 2) == 0);
      if (busy_list.size() != 0 && $urandom_range(0, 3) != 0)
        wb_rd = busy_list[$urandom_range(0, busy_list.size() - 1)];
      else
        wb_rd = 5'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};

      @(negedge clk);
      ref_decode(instr, legal, itype, mop, mimm);
      haz  = busy_now(instr[19:15]) || (instr[6:0] == 7'h33 && busy_now(instr[24:20])) ||
             busy_now(instr[11:7]);
      e_ir = !haz && (!m_ev || ex_ready);
      check("rnd_in_ready", {255'd0, in_ready}, {255'd0, e_ir});
      check("rnd_ex_valid", {255'd0, ex_valid}, {255'd0, m_ev});
      if (m_ev) check("rnd_bundle", {52'd0, bundle_act}, {52'd0, m_bnd});

      @(posedge clk);
      acc = in_valid && e_ir;
      if (acc) begin
        m_bnd = bnd(read_now(instr[19:15]),
                    (legal && !itype) ? read_now(instr[24:20]) : 64'd0,
                    (legal && itype) ? mimm : 64'd0,
                    mop, legal && itype, instr[11:7], legal, !legal);
        m_ev = 1;
      end else if (ex_ready) begin
        m_ev = 0;
      end
      if (wb_en) m_busy[wb_rd] = 0;
      if (acc && legal && instr[11:7] != 5'd0) m_busy[instr[11:7]] = 1;
      if (wb_en && wb_rd != 5'd0) m_reg[wb_rd] = wb_data;
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
